// File: rtl/rand_range_gen.sv
// Maximal-length Fibonacci LFSR with a request/valid port that draws unbiased
// values in [0, limit) by mask-and-reject sampling with a bounded retry count.
module rand_range_gen #(
  parameter int               WIDTH     = 16,
  parameter int               OUT_W     = 8,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [OUT_W-1:0] limit,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] rand_out,
  output logic [WIDTH-1:0] lfsr_state
);

  // Tap sets for the supported widths, packed so only the low WIDTH bits are used.
  localparam logic [31:0] TAP_ALL = (WIDTH == 8)  ? 32'h0000_00B8 :
                                    (WIDTH == 24) ? 32'h00E1_0000 :
                                    (WIDTH == 32) ? 32'h8020_0003 :
                                                    32'h0000_B400;
  localparam logic [WIDTH-1:0] TAPS     = TAP_ALL[WIDTH-1:0];
  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr_p0;
  logic [OUT_W-1:0] limit_p0, mask_p0;
  logic [TRY_W-1:0] tries_p0, tries_nxt;
  logic [OUT_W-1:0] rand_p1, rand_nxt;
  logic             vld_p1, vld_nxt;
  logic [OUT_W-1:0] sample;
  logic             accept;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [WIDTH-1:0] seed_sub(input logic [WIDTH-1:0] v);
    return (v == '0) ? SEED : v;
  endfunction

  // Smallest 2^k-1 covering limit-1; limit=0 wraps to all ones (full range).
  function automatic logic [OUT_W-1:0] range_mask(input logic [OUT_W-1:0] lim);
    logic [OUT_W-1:0] top;
    logic             seen;
    top  = lim - 1'b1;
    seen = 1'b0;
    range_mask = '0;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      seen          = seen | top[i];
      range_mask[i] = seen;
    end
  endfunction

  always_comb begin
    sample    = lfsr_p0[OUT_W-1:0] & mask_p0;
    accept    = (limit_p0 == '0) || (sample < limit_p0);
    state_nxt = state;
    tries_nxt = tries_p0;
    rand_nxt  = rand_p1;
    vld_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = DRAW;
          tries_nxt = '0;
        end
      end
      DRAW: begin
        if (accept) begin
          rand_nxt  = sample;
          vld_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (tries_p0 == LAST_TRY) begin
          // sample < 2*limit here, so the subtraction lands inside [0, limit).
          rand_nxt  = sample - limit_p0;
          vld_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tries_nxt = tries_p0 + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: control, LFSR and result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      rand_p1 <= '0;
      lfsr_p0 <= SEED;
    end else begin
      state   <= state_nxt;
      vld_p1  <= vld_nxt;
      rand_p1 <= rand_nxt;
      lfsr_p0 <= seed_load ? seed_sub(seed_in) : lfsr_step(lfsr_p0);
    end
  end

  // Draw parameters are only consumed in DRAW, so they carry no reset.
  always_ff @(posedge clk) begin
    tries_p0 <= tries_nxt;
    if (state == IDLE && req) begin
      limit_p0 <= limit;
      mask_p0  <= range_mask(limit);
    end
  end

  assign busy       = (state == DRAW);
  assign valid      = vld_p1;
  assign rand_out   = rand_p1;
  assign lfsr_state = lfsr_p0;

endmodule
